// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, byte width
// and the source-index width helper.
package uart_tx_arbiter_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LATCH = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4
  } state_t;

  // Index width for n sources; a single source still needs one bit.
  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: scans last+1, last+2, ... modulo N_SRC and
// returns the first requesting index.
module rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_SRC = 2,
  parameter int SRC_W = src_w(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [SRC_W-1:0] last,
  output logic [SRC_W-1:0] idx,
  output logic             any
);

  // Constant-index compares keep the scan free of variable bit-selects.
  always_comb begin
    idx = last;
    any = 1'b0;
    for (int k = 1; k <= N_SRC; k++) begin
      for (int s = 0; s < N_SRC; s++) begin
        if (!any && req[s] && (s == ((int'(last) + k) % N_SRC))) begin
          any = 1'b1;
          idx = SRC_W'(s);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_SRC byte FIFOs with round-robin
// arbitration and an optional per-grant burst lock.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_SRC = 2,
  parameter int BURST = 1,
  parameter int SRC_W = src_w(N_SRC)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_SRC-1:0]        buf_empty,
  output logic [N_SRC-1:0]        rd_en,
  input  logic [BYTE_W*N_SRC-1:0] buf_out,
  input  logic                    TxD_busy,
  output logic                    TxD_start,
  output logic [BYTE_W-1:0]       TxD_data,
  output logic [SRC_W-1:0]        grant_idx,
  output logic                    active,
  output state_t                  dbg_state
);

  localparam int CNT_W = src_w(BURST);

  state_t             r_state, w_state_nxt;
  logic [SRC_W-1:0]   r_grant, w_grant_nxt;
  logic [SRC_W-1:0]   r_last, w_last_nxt;
  logic [CNT_W-1:0]   r_burst_cnt, w_burst_nxt;
  logic               r_wait_first;
  logic [BYTE_W-1:0]  r_data;
  logic [N_SRC-1:0]   w_req;
  logic [N_SRC-1:0]   w_gnt_onehot;
  logic [BYTE_W-1:0]  w_sel_byte;
  logic [SRC_W-1:0]   w_pick_idx;
  logic               w_any;
  logic               w_gnt_empty;
  logic               w_burst_more;

  assign w_req = ~buf_empty;

  rr_pick #(
    .N_SRC (N_SRC),
    .SRC_W (SRC_W)
  ) u_pick (
    .req  (w_req),
    .last (r_last),
    .idx  (w_pick_idx),
    .any  (w_any)
  );

  always_comb begin
    w_gnt_onehot = '0;
    w_sel_byte   = '0;
    for (int s = 0; s < N_SRC; s++) begin
      if (r_grant == SRC_W'(s)) begin
        w_gnt_onehot[s] = 1'b1;
        w_sel_byte      = buf_out[s*BYTE_W +: BYTE_W];
      end
    end
  end

  assign w_gnt_empty  = |(buf_empty & w_gnt_onehot);
  assign w_burst_more = (int'(r_burst_cnt) < (BURST - 1));

  // Handshake with the transmitter: TxD_start is a one-cycle request that is
  // never acknowledged directly; TxD_busy rises one cycle later and the byte is
  // done when it falls, so the first WAIT cycle ignores TxD_busy.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_burst_nxt = r_burst_cnt;
    case (r_state)
      ST_IDLE: begin
        if (!TxD_busy && w_any) begin
          w_grant_nxt = w_pick_idx;
          w_burst_nxt = '0;
          w_state_nxt = ST_READ;
        end
      end
      ST_READ:  w_state_nxt = ST_LATCH;
      ST_LATCH: w_state_nxt = ST_START;
      ST_START: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (!r_wait_first && !TxD_busy) begin
          if (w_burst_more && !w_gnt_empty) begin
            w_burst_nxt = r_burst_cnt + 1'b1;
            w_state_nxt = ST_READ;
          end else begin
            w_last_nxt  = r_grant;
            w_burst_nxt = '0;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last       <= SRC_W'(N_SRC - 1);
      r_burst_cnt  <= '0;
      r_wait_first <= 1'b0;
      r_data       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last       <= w_last_nxt;
      r_burst_cnt  <= w_burst_nxt;
      r_wait_first <= (r_state == ST_START);
      if (r_state == ST_LATCH) begin
        r_data <= w_sel_byte;
      end
    end
  end

  assign rd_en     = (r_state == ST_READ) ? w_gnt_onehot : '0;
  assign TxD_start = (r_state == ST_START);
  assign TxD_data  = r_data;
  assign grant_idx = r_grant;
  assign active    = (r_state != ST_IDLE);
  assign dbg_state = r_state;

endmodule
